// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADD_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused every RUN cycle by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell stepped LSB-first for WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last    = (cnt == CNT_W'(WIDTH - 1));
    // Lower WIDTH-1 result bits live in sum_sh; the MSB comes straight from the cell.
    assign sum_nxt = {fa_s, sum_sh};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    // Counter parks at WIDTH-1 rather than wrapping.
                    if (!last) cnt <= cnt + 1'b1;
                    if (last) begin
                        sum  <= sum_nxt;
                        cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf  <= carry ^ fa_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         ovf_obs;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf_obs), 32'(exp_ovf));
`endif
    endtask

    // One addition; poke_cyc re-pulses start in that RUN cycle, rst_cyc aborts there.
    task automatic do_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci, input int poke_cyc, input int rst_cyc);
        logic [W:0] full;
        full = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
        @(negedge clk);
        start = 1'b1; a = ai; b = bi; cin = ci;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int c = 1; c <= W; c++) begin
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done_run"}, 32'(done), 32'd0);
            if (c == 1) chk_result({tag, ".held"});
            if (c == rst_cyc) begin
                @(negedge clk); rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
                exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
                chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
                chk({tag, ".rst_done"}, 32'(done), 32'd0);
                chk_result({tag, ".rst"});
                @(posedge clk); #1;
                chk({tag, ".rst_nodone"}, 32'(done), 32'd0);
                return;
            end
            if (c == poke_cyc) begin
                @(negedge clk);
                start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (ai[W-1] == bi[W-1]) && (full[W-1] != ai[W-1]);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk_result(tag);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk_result({tag, ".hold"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_result("reset");
        rst = 1'b0;

        do_op("5a_3c", 8'h5A, 8'h3C, 1'b0, -1, -1);
        do_op("ff_01", 8'hFF, 8'h01, 1'b0, -1, -1);
        do_op("00_00_c", 8'h00, 8'h00, 1'b1, -1, -1);
        do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, -1, -1);
        do_op("poke", 8'h12, 8'h34, 1'b0, 3, -1);
        do_op("abort", 8'hA5, 8'h5A, 1'b1, -1, 4);
        do_op("after_abort", 8'hC3, 8'h3D, 1'b0, -1, -1);
        do_op("7f_01", 8'h7F, 8'h01, 1'b0, -1, -1);
        do_op("80_80", 8'h80, 8'h80, 1'b0, -1, -1);
        do_op("10_20", 8'h10, 8'h20, 1'b0, -1, -1);

        // rst wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        chk("rst_prio.busy", 32'(busy), 32'd0);
        chk_result("rst_prio");

        for (int i = 0; i < 30; i++) begin
            do_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom),
                  (i % 5 == 0) ? int'($urandom_range(1, W)) : -1,
                  (i % 7 == 3) ? int'($urandom_range(1, W)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
